poc_system: RTL and testbench



---
 rtl/poc_pkg.sv | 20 ++
 rtl/poc_printer.sv | 41 ++++
 rtl/poc_system.sv | 134 +++++++++++++
 tb/tb_poc_system.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/poc_pkg.sv
// Shared types and constants for the programmable-output-controller system.
package poc_pkg;

    typedef enum logic [1:0] {
        P_IDLE,
        P_POLL,
        P_IRQ_WAIT
    } proc_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_SEND,
        C_WAIT
    } poc_state_e;

    localparam int          SR_READY = 7;
    localparam int          SR_IE    = 0;
    localparam logic [7:0]  SR_RESET = 8'h80;

endpackage

// File: rtl/poc_printer.sv
// Printer model: accepts a byte on TR while ready, then stays busy for PRINT_CYCLES clocks.
// RDY drops on the accepting edge and rises one edge after the counter has drained.
module poc_printer #(
    parameter int PRINT_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tr_i,
    input  logic [7:0] pd_i,
    output logic       rdy_o,
    output logic [7:0] data_o
);

    localparam int CW = $clog2(PRINT_CYCLES + 1);

    logic          rdy_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q  <= 1'b1;
            cnt_q  <= '0;
            data_q <= 8'h00;
        end else if (!rdy_q) begin
            if (cnt_q == '0) begin
                rdy_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else if (tr_i) begin
            data_q <= pd_i;
            rdy_q  <= 1'b0;
            cnt_q  <= CW'(PRINT_CYCLES);
        end
    end

    assign rdy_o  = rdy_q;
    assign data_o = data_q;

endmodule

// File: rtl/poc_system.sv
// POC system top: processor model hands a byte to the POC via SR/BR, POC drives the printer.
// Optional debug outputs (irq, poc_ready, busy) are enabled with POC_DEBUG_PORTS_EN.
module poc_system
    import poc_pkg::*;
#(
    parameter int PRINT_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       func,
    input  logic [7:0] data_input,
    input  logic       Switch,
`ifdef POC_DEBUG_PORTS_EN
    output logic       irq_o,
    output logic       poc_ready_o,
    output logic       busy_o,
`endif
    output logic [7:0] data
);

    logic        func_q;
    proc_state_e proc_q;
    poc_state_e  poc_q;
    logic [7:0]  pend_q;
    logic        mode_q;
    logic [7:0]  br_q;
    logic [7:0]  sr_q;
    logic [7:0]  sr_d;
    logic [7:0]  pd_q;
    logic        tr_q;
    logic        rdy;

    logic req;
    logic irq;
    logic take_job;
    logic arm_ie;
    logic set_ready;

    assign req       = func & ~func_q;
    assign irq       = sr_q[SR_READY] & sr_q[SR_IE];
    // Interrupt enable is armed one edge after acceptance; the ISR runs on the following edge.
    assign arm_ie    = (proc_q == P_IRQ_WAIT) && mode_q && !sr_q[SR_IE];
    assign take_job  = ((proc_q == P_POLL) && sr_q[SR_READY]) ||
                       ((proc_q == P_IRQ_WAIT) && irq);
    assign set_ready = (poc_q == C_WAIT) && rdy;

    always_comb begin
        sr_d = sr_q;
        if (arm_ie) begin
            sr_d[SR_IE] = 1'b1;
        end
        if (take_job) begin
            sr_d[SR_READY] = 1'b0;
            sr_d[SR_IE]    = 1'b0;
        end
        if (set_ready) begin
            sr_d[SR_READY] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            func_q <= 1'b0;
            proc_q <= P_IDLE;
            poc_q  <= C_IDLE;
            pend_q <= 8'h00;
            mode_q <= 1'b0;
            br_q   <= 8'h00;
            sr_q   <= SR_RESET;
            pd_q   <= 8'h00;
            tr_q   <= 1'b0;
        end else begin
            func_q <= func;
            sr_q   <= sr_d;

            case (proc_q)
                P_IDLE: begin
                    if (req) begin
                        pend_q <= data_input;
                        mode_q <= Switch;
                        proc_q <= Switch ? P_IRQ_WAIT : P_POLL;
                    end
                end
                P_POLL, P_IRQ_WAIT: begin
                    if (take_job) begin
                        br_q   <= pend_q;
                        proc_q <= P_IDLE;
                    end
                end
                default: proc_q <= P_IDLE;
            endcase

            case (poc_q)
                C_IDLE: begin
                    if (!sr_q[SR_READY] && rdy) begin
                        pd_q  <= br_q;
                        tr_q  <= 1'b1;
                        poc_q <= C_SEND;
                    end
                end
                C_SEND: begin
                    tr_q <= 1'b0;
                    if (!rdy) begin
                        poc_q <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    if (rdy) begin
                        poc_q <= C_IDLE;
                    end
                end
                default: poc_q <= C_IDLE;
            endcase
        end
    end

    poc_printer #(
        .PRINT_CYCLES(PRINT_CYCLES)
    ) u_printer (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .tr_i   (tr_q),
        .pd_i   (pd_q),
        .rdy_o  (rdy),
        .data_o (data)
    );

`ifdef POC_DEBUG_PORTS_EN
    assign irq_o       = irq;
    assign poc_ready_o = sr_q[SR_READY];
    assign busy_o      = (proc_q != P_IDLE) || (poc_q != C_IDLE) || !rdy;
`endif

endmodule

// File: tb/tb_poc_system.sv
// Scoreboarded bench for poc_system: stimulus queues expected prints, a monitor checks each one.
module tb_poc_system;

    localparam int PC = 4;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       func;
    logic [7:0] data_input;
    logic       Switch;
    logic [7:0] data;

    always #5 CLK = ~CLK;

    poc_system #(.PRINT_CYCLES(PC)) u_dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .func       (func),
        .data_input (data_input),
        .Switch     (Switch),
        .data       (data)
    );

    typedef struct {
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   e0;
    logic prev_rdy = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic start_job(input logic [7:0] b, input logic mode, input int lat);
        exp_t e;
        e0         = cyc;
        data_input = b;
        Switch     = mode;
        func       = 1'b1;
        e.d        = b;
        e.at       = e0 + lat;
        sb.push_back(e);
    endtask

    // A print is the printer's RDY falling; each must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (prev_rdy && !u_dut.rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_print: got data %0h with nothing expected (cycle %0d)", data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("print_data", data, e.d);
                check("print_edge", cyc, e.at);
            end
        end
        prev_rdy <= u_dut.rdy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RSTn       = 1'b0;
        func       = 1'b0;
        Switch     = 1'b0;
        data_input = 8'h11;
        repeat (100) begin
            @(negedge CLK);
            func       = ~func;
            data_input = data_input + 8'h01;
        end
        check("rst_data", data, 8'h00);
        check("rst_sr", u_dut.sr_q, 8'h80);
        check("rst_rdy", u_dut.rdy, 1'b1);
        func = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_data", data, 8'h00);
        check("post_rst_sr", u_dut.sr_q, 8'h80);

        // Polling job with func held high: single print at edge 4.
        @(negedge CLK);
        start_job(8'hF0, 1'b0, 4);
        wait_until(e0 + 3);
        check("poll_e3_data", data, 8'h00);
        wait_until(e0 + 4);
        check("poll_e4_data", data, 8'hF0);
        wait_until(e0 + 4 + PC + 1);
        check("poll_sr7_early", u_dut.sr_q[7], 1'b0);
        wait_until(e0 + 4 + PC + 2);
        check("poll_sr7_back", u_dut.sr_q[7], 1'b1);
        wait_until(e0 + 100);
        func = 1'b0;

        repeat (3) @(negedge CLK);
        start_job(8'h0F, 1'b0, 4);
        wait_until(e0 + 3);
        check("poll2_e3_data", data, 8'hF0);
        wait_until(e0 + 4 + PC + 2);
        check("poll2_sr7_back", u_dut.sr_q[7], 1'b1);
        func = 1'b0;

        // Interrupt job; Switch flipped mid-job must not matter.
        @(negedge CLK);
        start_job(8'h6F, 1'b1, 5);
        wait_until(e0 + 1);
        Switch = 1'b0;
        check("irq_e1_ie", u_dut.sr_q[0], 1'b0);
        wait_until(e0 + 2);
        check("irq_e2_ie", u_dut.sr_q[0], 1'b1);
        check("irq_e2_irq", u_dut.irq, 1'b1);
        wait_until(e0 + 4);
        check("irq_e4_data", data, 8'h0F);
        wait_until(e0 + 5);
        check("irq_e5_data", data, 8'h6F);
        check("irq_e5_ie", u_dut.sr_q[0], 1'b0);
        wait_until(e0 + 5 + PC + 2);
        check("irq_sr", u_dut.sr_q, 8'h80);
        func = 1'b0;

        // Second rising edge while the first job is in flight is dropped.
        @(negedge CLK);
        start_job(8'h55, 1'b1, 5);
        wait_until(e0 + 1);
        func = 1'b0;
        wait_until(e0 + 2);
        func       = 1'b1;
        data_input = 8'hAA;
        wait_until(e0 + 5 + PC + 2);
        check("drop_sr7_back", u_dut.sr_q[7], 1'b1);
        repeat (12) @(negedge CLK);
        check("drop_data", data, 8'h55);
        check("drop_sb_empty", sb.size(), 0);
        func = 1'b0;

        // Reset pulse while the printer is busy, then a normal job.
        @(negedge CLK);
        start_job(8'h99, 1'b0, 4);
        wait_until(e0 + 6);
        RSTn = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_sr", u_dut.sr_q, 8'h80);
        check("midrst_rdy", u_dut.rdy, 1'b1);
        @(negedge CLK);
        func = 1'b0;
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        start_job(8'h3C, 1'b0, 4);
        wait_until(e0 + 4);
        check("after_rst_data", data, 8'h3C);
        wait_until(e0 + 4 + PC + 2);
        check("after_rst_sr7", u_dut.sr_q[7], 1'b1);
        func = 1'b0;

        repeat (5) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
